// File: rtl/mem_write_fsm_if.sv
// ---------------------------------------------------------------------------
// mem_write_fsm_if
//
// Bundles the signals between the ToF front end, the write sequencer and the
// ToF data BRAMs.
//
// Signals:
//   ToF_dr           [N_SENSORS-1:0]  per-sensor data-ready level (front end -> sequencer)
//   wea              1                BRAM port-A write enable, one-cycle pulse per word
//   ToF_Index        [2:0]            selected sensor (front-end mux select, BRAM addr[8:6])
//   all_data_written 1                one-cycle pulse when every sensor finished a frame
//
// Modports:
//   master : the sequencer (drives wea / ToF_Index / all_data_written, reads ToF_dr)
//   slave  : the front-end / BRAM side (drives ToF_dr, observes the rest)
// ---------------------------------------------------------------------------
interface mem_write_fsm_if #(
    parameter int N_SENSORS = 8
);
    logic [N_SENSORS-1:0] ToF_dr;
    logic                 wea;
    logic [2:0]           ToF_Index;
    logic                 all_data_written;

    modport master (
        input  ToF_dr,
        output wea,
        output ToF_Index,
        output all_data_written
    );

    modport slave (
        output ToF_dr,
        input  wea,
        input  ToF_Index,
        input  all_data_written
    );
endinterface

// File: rtl/mem_write_fsm.sv
// ---------------------------------------------------------------------------
// mem_write_fsm
//
// Write-sequencing controller between the eight-sensor I2C ToF front end and
// the ToF data BRAMs. Each rising edge on a sensor's data-ready line is
// latched as a pending request. The controller picks one pending sensor,
// steers the front-end mux to it through ToF_Index, waits one settle cycle
// and then issues a single-cycle BRAM write enable. Per-sensor word counts
// (saturating at WORDS_PER_FRAME) track frame progress; once every sensor has
// delivered a full frame a one-cycle all_data_written pulse starts the
// downstream readout and the counts restart from zero.
//
// Parameters:
//   N_SENSORS        number of sensors (width of ToF_dr), at most 8 since
//                    ToF_Index is 3 bits wide
//   WORDS_PER_FRAME  words per sensor per frame
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    mem_write_fsm_if.master (ToF_dr in; wea, ToF_Index,
//          all_data_written out)
//
// Build option:
//   MEM_WRITE_RR_EN  defined   -> round-robin selection starting one past the
//                                 last served sensor
//                    undefined -> fixed priority, lowest pending index wins
//
// Cycle budget per word: IDLE (pick) -> SELECT (settle) -> WRITE (wea=1),
// plus one DONE cycle when a frame completes.
// ---------------------------------------------------------------------------
module mem_write_fsm #(
    parameter int N_SENSORS       = 8,
    parameter int WORDS_PER_FRAME = 64
) (
    input  logic             clk,
    input  logic             reset,
    mem_write_fsm_if.master  bus
);

    // Counts are at least 7 bits; wider only if the frame size demands it.
    localparam int CNT_W = ($clog2(WORDS_PER_FRAME + 1) > 7) ?
                           $clog2(WORDS_PER_FRAME + 1) : 7;
    localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(WORDS_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_reg,   state_next;
    logic [2:0]           index_reg,   index_next;
    logic [N_SENSORS-1:0] dr_q_reg;
    logic [N_SENSORS-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0]     count_reg  [N_SENSORS];
    logic [CNT_W-1:0]     count_next [N_SENSORS];
`ifdef MEM_WRITE_RR_EN
    logic [2:0]           last_served_reg, last_served_next;
`endif

    // ------------------------------------------------------------------
    // Control strobes from the FSM
    // ------------------------------------------------------------------
    logic                 count_en;      // WRITE: account the selected sensor's word
    logic                 clear_counts;  // DONE: restart the frame
    logic [N_SENSORS-1:0] clear_mask;    // WRITE: retire the served request

    // ------------------------------------------------------------------
    // Per-sensor datapath
    // ------------------------------------------------------------------
    logic [N_SENSORS-1:0] rise;
    logic [N_SENSORS-1:0] sel_onehot;
    logic [N_SENSORS-1:0] full_after;
    logic                 all_full_after;

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_sensor
            // A level held high yields only one event: compare against the
            // previous cycle's sample.
            assign rise[gi]       = bus.ToF_dr[gi] & ~dr_q_reg[gi];
            assign sel_onehot[gi] = (index_reg == 3'(gi));

            // Saturating word counter. Words beyond a full frame still get
            // written to BRAM but do not advance the count.
            always_comb begin
                count_next[gi] = count_reg[gi];
                if (clear_counts) begin
                    count_next[gi] = '0;
                end else if (count_en && sel_onehot[gi] &&
                             (count_reg[gi] < FRAME_WORDS)) begin
                    count_next[gi] = count_reg[gi] + CNT_W'(1);
                end
            end

            // Frame-complete test looks at the post-update count so the
            // decision is made in the same WRITE cycle as the last word.
            assign full_after[gi] = (count_next[gi] >= FRAME_WORDS);

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg[gi] <= '0;
                end else begin
                    count_reg[gi] <= count_next[gi];
                end
            end
        end
    endgenerate

    assign all_full_after = &full_after;

    // A rise on the sensor being retired in the same cycle wins over the
    // clear, so back-to-back words on one sensor are never dropped.
    assign pending_next = (pending_reg & ~clear_mask) | rise;

    // ------------------------------------------------------------------
    // Request selection
    // ------------------------------------------------------------------
    logic       pick_valid;
    logic [2:0] pick_idx;

`ifdef MEM_WRITE_RR_EN
    // Scan from last_served+1 upward with wrap. The loop runs in reverse
    // scan order so the last hit assigned is the first in scan order.
    always_comb begin
        int j;
        j          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_SENSORS; k >= 1; k--) begin
            j = int'(last_served_reg) + k;
            if (j >= N_SENSORS) begin
                j = j - N_SENSORS;
            end
            if (pending_reg[j]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(j);
            end
        end
    end
`else
    // Fixed priority: lowest pending index wins (reverse loop, last hit kept).
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_SENSORS - 1; k >= 0; k--) begin
            if (pending_reg[k]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: next-state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        count_en     = 1'b0;
        clear_counts = 1'b0;
        clear_mask   = '0;
`ifdef MEM_WRITE_RR_EN
        last_served_next = last_served_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                // ToF_Index only moves here, so it is stable through
                // SELECT and WRITE while the front-end mux settles.
                if (pick_valid) begin
                    index_next = pick_idx;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                state_next = WRITE;
            end
            WRITE: begin
                count_en   = 1'b1;
                clear_mask = sel_onehot;
`ifdef MEM_WRITE_RR_EN
                last_served_next = index_reg;
`endif
                state_next = all_full_after ? DONE : IDLE;
            end
            DONE: begin
                clear_counts = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            dr_q_reg    <= '0;
            pending_reg <= '0;
`ifdef MEM_WRITE_RR_EN
            // Start one before sensor 0 so sensor 0 is scanned first.
            last_served_reg <= 3'(N_SENSORS - 1);
`endif
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            dr_q_reg    <= bus.ToF_dr;
            pending_reg <= pending_next;
`ifdef MEM_WRITE_RR_EN
            last_served_reg <= last_served_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore, straight from state / index registers)
    // ------------------------------------------------------------------
    assign bus.wea              = (state_reg == WRITE);
    assign bus.all_data_written = (state_reg == DONE);
    assign bus.ToF_Index        = index_reg;

endmodule

// File: tb/tb_mem_write_fsm.sv
// ---------------------------------------------------------------------------
// tb_mem_write_fsm
//
// Directed sequence with randomized sensor timing. A timeline model predicts,
// edge by edge, when each write and frame-complete pulse must appear and which
// sensor is selected; the bench compares wea / ToF_Index / all_data_written
// every cycle and checks pulse totals and write order at the end of each step.
// Build with +define+MEM_WRITE_RR_EN for the round-robin variant.
// ---------------------------------------------------------------------------
module tb_mem_write_fsm;

    localparam int N = 8;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_write_fsm_if #(.N_SENSORS(N)) bus ();

    mem_write_fsm #(
        .N_SENSORS      (N),
        .WORDS_PER_FRAME(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observed activity
    int wea_seen;
    int adw_seen;
    int adw_after;     // number of writes seen when the frame pulse appeared
    int order_q[$];

    // Stimulus
    logic [N-1:0] dr;

    // Timeline model
    logic [N-1:0] m_prev, m_pend;
    int           m_cnt[N];
    int           m_last, m_cur;
    int           m_free;      // first edge at which a new sensor may be picked
    int           m_wr;        // edge that retires the write in flight (-1 none)
    int           m_done;      // edge that restarts the frame (-1 none)
    int           e;           // edge number
    logic         exp_wea, exp_adw;
    logic [2:0]   exp_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p);
`ifdef MEM_WRITE_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (p[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (p[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_last  = N - 1;
        m_cur   = 0;
        m_free  = 0;
        m_wr    = -1;
        m_done  = -1;
        exp_wea = 1'b0;
        exp_adw = 1'b0;
        exp_idx = '0;
    endtask

    // Apply one clock edge to the model with the inputs that were present.
    task automatic model_edge(input logic rst, input logic [N-1:0] d);
        logic [N-1:0] old, rs, tmp;
        bit full;
        e++;
        if (rst) begin
            model_reset();
            return;
        end
        old    = m_pend;
        rs     = d & ~m_prev;
        m_prev = d;
        m_pend = old | rs;
        exp_adw = 1'b0;
        if (e == m_wr) begin
            tmp        = old;
            tmp[m_cur] = 1'b0;
            m_pend     = tmp | rs;
            if (m_cnt[m_cur] < W) m_cnt[m_cur]++;
            m_last = m_cur;
            full = 1;
            for (int i = 0; i < N; i++) if (m_cnt[i] < W) full = 0;
            if (full) begin
                exp_adw = 1'b1;
                m_done  = e + 1;
                m_free  = e + 2;
            end else begin
                m_free  = e + 1;
            end
            m_wr = -1;
        end else if (e == m_done) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_done = -1;
        end else if (m_wr < 0 && e >= m_free && old != '0) begin
            m_cur   = pick(old);
            exp_idx = 3'(m_cur);
            m_wr    = e + 2;
        end
        exp_wea = (m_wr >= 0) && (e == m_wr - 1);
    endtask

    task automatic tick();
        bus.ToF_dr = dr;
        @(posedge clk);
        model_edge(reset, dr);
        @(negedge clk);
        check("wea", 32'(bus.wea), 32'(exp_wea));
        check("all_data_written", 32'(bus.all_data_written), 32'(exp_adw));
        check("ToF_Index", 32'(bus.ToF_Index), 32'(exp_idx));
        if (bus.wea === 1'b1) begin
            wea_seen++;
            order_q.push_back(int'(bus.ToF_Index));
        end
        if (bus.all_data_written === 1'b1) begin
            adw_seen++;
            adw_after = wea_seen;
        end
    endtask

    task automatic clear_obs();
        wea_seen  = 0;
        adw_seen  = 0;
        adw_after = -1;
        order_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One 36-cycle round: each sensor in mask rises at a random offset 0..3
    // and holds for 20 cycles, keeping rises on one sensor >= 33 cycles apart.
    task automatic round(input logic [N-1:0] mask);
        int off[N];
        for (int i = 0; i < N; i++) off[i] = int'($urandom_range(0, 3));
        for (int c = 0; c < 36; c++) begin
            for (int i = 0; i < N; i++)
                dr[i] = mask[i] && (c >= off[i]) && (c < off[i] + 20);
            tick();
        end
        dr = '0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        idle(cycles);
        reset = 1'b0;
    endtask

    initial begin
        int exp_order[3];
        e     = 0;
        dr    = '1;
        reset = 1'b1;
        bus.ToF_dr = dr;
        model_reset();
        clear_obs();

        // Step 1: reset with all data-ready lines high -> outputs idle, then
        // every sensor counts as a fresh rise and is written in index order.
        idle(2);
        check("reset_wea", 32'(bus.wea), 32'd0);
        check("reset_index", 32'(bus.ToF_Index), 32'd0);
        check("reset_adw", 32'(bus.all_data_written), 32'd0);
        reset = 1'b0;
        clear_obs();
        idle(30);
        check("post_reset_writes", 32'(wea_seen), 32'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            check("post_reset_order", 32'(order_q[i]), 32'(i));
        dr = '0;
        idle(40);

        // Step 2: single event on sensor 3 with exact latency.
        clear_obs();
        dr[3] = 1'b1;
        tick();                                   // edge k: rise sampled
        tick();                                   // edge k+1: select
        check("single_index_k1", 32'(bus.ToF_Index), 32'd3);
        check("single_wea_k1", 32'(bus.wea), 32'd0);
        tick();                                   // edge k+2: write
        check("single_wea_k2", 32'(bus.wea), 32'd1);
        tick();
        check("single_wea_k3", 32'(bus.wea), 32'd0);
        idle(30);                                 // level stays high
        check("single_writes", 32'(wea_seen), 32'd1);
        dr = '0;
        idle(40);

        // Step 3: rises on 2 and 5, then a fresh rise on 2 landing on the
        // edge that retires sensor 2's first write.
        clear_obs();
        dr = '0;
        dr[2] = 1'b1;
        dr[5] = 1'b1;
        tick();
        tick();
        dr[2] = 1'b0;
        tick();
        dr[2] = 1'b1;
        tick();
        idle(20);
`ifdef MEM_WRITE_RR_EN
        exp_order = '{2, 5, 2};
`else
        exp_order = '{2, 2, 5};
`endif
        check("pair_writes", 32'(order_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < order_q.size(); i++)
            check("pair_order", 32'(order_q[i]), 32'(exp_order[i]));
        dr = '0;
        idle(40);

        // Step 4: clean frame -> one pulse right after the 512th write.
        do_reset(2);
        clear_obs();
        for (int r = 0; r < W; r++) round('1);
        idle(40);
        check("frame_writes", 32'(wea_seen), 32'(N * W));
        check("frame_pulses", 32'(adw_seen), 32'd1);
        check("frame_pulse_after", 32'(adw_after), 32'(N * W));

        // Step 5: counts restarted; an extra word on sensor 0 is written but
        // not counted.
        clear_obs();
        round(8'h01);
        for (int r = 0; r < W; r++) round('1);
        idle(40);
        check("sat_writes", 32'(wea_seen), 32'(N * W + 1));
        check("sat_pulses", 32'(adw_seen), 32'd1);
        check("sat_pulse_after", 32'(adw_after), 32'(N * W + 1));

        // Step 6: random partial traffic, reset mid-frame, then a full frame.
        clear_obs();
        while (wea_seen < 100) round(N'($urandom_range(1, (1 << N) - 1)));
        check("mid_no_pulse", 32'(adw_seen), 32'd0);
        do_reset(1);
        clear_obs();
        for (int r = 0; r < W; r++) round('1);
        idle(40);
        check("mid_writes", 32'(wea_seen), 32'(N * W));
        check("mid_pulses", 32'(adw_seen), 32'd1);
        check("mid_pulse_after", 32'(adw_after), 32'(N * W));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
